noc_out_port_arbiter: RTL and testbench

Output-port arbiter and flow controller for one direction (N, S, E, W or processor) of a tile's dynamic-network router, used identically on noc1, noc2 and noc3. It shares one outgoing link among the router's input ports with round-robin fairness. Once an input wins, the arbiter holds the link for that input's whole wormhole packet, using the length field in the header flit. It sends flits only while downstream credit is available and restores credit from the downstream yummy pulses.

---
 rtl/noc_out_port_arbiter.sv | 129 ++++++++++++
 tb/tb_noc_out_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_out_port_arbiter.sv
// Output-port arbiter for one router direction: round-robin header arbitration,
// wormhole hold for the packet body, and credit-based flow control from yummy pulses.
module noc_out_port_arbiter #(
    parameter int unsigned NUM_IN     = 5,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CREDITS    = 4,
    parameter int unsigned LEN_LSB    = 22,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_IN-1:0]            in_valid,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]            in_pop,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         out_yummy,
    output logic [NUM_IN-1:0]            grant,
    output logic                         credit_err
);

    localparam int unsigned CW = $clog2(CREDITS + 1);
    localparam int unsigned IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic {StIdle, StBody} state_e;

    state_e                  state_q;
    logic [CW-1:0]           credit_q, credit_d;
    logic [LEN_WIDTH-1:0]    remaining_q;
    logic [IW-1:0]           last_q;
    logic [NUM_IN-1:0]       grant_q;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic                    credit_err_q, credit_err_d;

    logic [IW-1:0]           rr_idx;
    logic                    rr_found;
    logic [IW-1:0]           sel_idx;
    logic                    send;
    logic [DATA_WIDTH-1:0]   sel_flit;
    logic [LEN_WIDTH-1:0]    hdr_len;
    int unsigned             cand;

    // Search starts just after the last winner and wraps.
    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        cand     = 0;
        for (int unsigned k = 1; k <= NUM_IN; k++) begin
            cand = (int'(last_q) + k) % NUM_IN;
            if (!rr_found && in_valid[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand[IW-1:0];
            end
        end
    end

    // During a body the owner is the last winner, so last_q doubles as the owner index.
    always_comb begin
        sel_idx  = (state_q == StBody) ? last_q : rr_idx;
        send     = (credit_q != '0) &&
                   ((state_q == StBody) ? in_valid[last_q] : rr_found);
        in_pop   = send ? ({{(NUM_IN-1){1'b0}}, 1'b1} << sel_idx) : '0;
        sel_flit = in_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];
        hdr_len  = sel_flit[LEN_LSB +: LEN_WIDTH];
    end

    always_comb begin
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        if (send && !out_yummy) begin
            credit_d = credit_q - 1'b1;
        end else if (!send && out_yummy) begin
            if (credit_q == CW'(CREDITS)) begin
                credit_err_d = 1'b1;
            end else begin
                credit_d = credit_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            credit_q     <= CW'(CREDITS);
            remaining_q  <= '0;
            last_q       <= IW'(NUM_IN - 1);
            grant_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            credit_err_q <= 1'b0;
        end else begin
            credit_q     <= credit_d;
            credit_err_q <= credit_err_d;
            out_valid_q  <= send;
            if (send) begin
                out_data_q <= sel_flit;
            end
            case (state_q)
                StIdle: begin
                    if (send) begin
                        last_q      <= rr_idx;
                        remaining_q <= hdr_len;
                        if (hdr_len != '0) begin
                            state_q <= StBody;
                            grant_q <= in_pop;
                        end
                    end
                end
                StBody: begin
                    if (send) begin
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == LEN_WIDTH'(1)) begin
                            state_q <= StIdle;
                            grant_q <= '0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign grant      = grant_q;
    assign credit_err = credit_err_q;

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// Self-checking bench for noc_out_port_arbiter: directed scenarios plus a randomized
// run, all compared against a packet-level reference model.
module tb_noc_out_port_arbiter;

    localparam int N  = 5;
    localparam int DW = 64;
    localparam int CR = 4;
    localparam int LL = 22;
    localparam int LW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_pop;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_yummy;
    logic [N-1:0]    grant;
    logic            credit_err;

    noc_out_port_arbiter #(
        .NUM_IN(N), .DATA_WIDTH(DW), .CREDITS(CR), .LEN_LSB(LL), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_pop(in_pop),
        .out_valid(out_valid), .out_data(out_data), .out_yummy(out_yummy), .grant(grant),
        .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: credits as a plain count, packet ownership as flits-left-in-body.
    int            m_credit, m_last, m_left;
    bit            m_err, m_ev;
    logic [DW-1:0] m_ed;
    logic [N-1:0]  obs_pop, exp_pop;

    function automatic void model_reset();
        m_credit = CR; m_last = N - 1; m_left = 0; m_err = 0; m_ev = 0; m_ed = '0;
    endfunction

    function automatic logic [N-1:0] model_pop();
        logic [N-1:0] r = '0;
        if (m_credit == 0) return r;
        if (m_left > 0) begin
            if (in_valid[m_last]) r[m_last] = 1'b1;
            return r;
        end
        for (int k = 1; k <= N; k++) begin
            int c = (m_last + k) % N;
            if (in_valid[c]) begin
                r[c] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] r = '0;
        if (m_left > 0) r[m_last] = 1'b1;
        return r;
    endfunction

    function automatic void model_advance(input logic [N-1:0] p);
        bit sent = (p != '0);
        m_ev = sent;
        if (sent) begin
            int idx = 0;
            for (int i = 0; i < N; i++) if (p[i]) idx = i;
            m_ed = in_data[idx*DW +: DW];
            if (m_left > 0) m_left--;
            else begin
                m_last = idx;
                m_left = int'(m_ed[LL +: LW]);
            end
        end
        if (sent && !out_yummy) m_credit--;
        else if (!sent && out_yummy) begin
            if (m_credit == CR) m_err = 1;
            else m_credit++;
        end
    endfunction

    function automatic logic [DW-1:0] mk(input int len);
        logic [DW-1:0] f = {$urandom, $urandom};
        f[LL +: LW] = len[LW-1:0];
        return f;
    endfunction

    // Drive one cycle from posedge+1; in_pop is sampled just before the next edge.
    task automatic tick(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic y);
        in_valid = v; in_data = d; out_yummy = y;
        #3;
        obs_pop = in_pop;
        exp_pop = model_pop();
        @(posedge clk);
        model_advance(exp_pop);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = '0; in_data = '0; out_yummy = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = '0; in_data = '0; out_yummy = 1'b0;
        #1;
        total += 4;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        if (grant !== '0) begin bad++; $display("FAIL reset_grant got=%b want=0", grant); end
        if (credit_err !== 1'b0) begin bad++; $display("FAIL reset_credit_err got=%b want=0", credit_err); end
        if (in_pop !== '0) begin bad++; $display("FAIL reset_in_pop got=%b want=0", in_pop); end
        do_reset();
    endtask

    task automatic test_single_packet();
        logic [N*DW-1:0] bus;
        logic [DW-1:0]   q[$];
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bus = '0;
            bus[2*DW +: DW] = mk(i == 0 ? 3 : int'($urandom_range(0, 255)));
            if (i < 4) q.push_back(bus[2*DW +: DW]);
            tick((i < 4) ? 5'b00100 : 5'b00000, bus, out_valid);
            total += 2;
            if (obs_pop !== ((i < 4) ? 5'b00100 : 5'b00000)) begin
                bad++; $display("FAIL single_pop cyc=%0d got=%b", i, obs_pop);
            end
            if (grant !== ((i < 3) ? 5'b00100 : 5'b00000)) begin
                bad++; $display("FAIL single_grant cyc=%0d got=%b", i, grant);
            end
            if (i < 4) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== q[0]) begin
                    bad++; $display("FAIL single_data cyc=%0d got=%b/%h want=1/%h", i, out_valid, out_data, q[0]);
                end
                void'(q.pop_front());
            end else begin
                total++;
                if (out_valid !== 1'b0) begin bad++; $display("FAIL single_tail cyc=%0d got=%b want=0", i, out_valid); end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [N*DW-1:0] bus;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < N; j++) bus[j*DW +: DW] = mk(0);
            tick('1, bus, out_valid);
            total += 3;
            if (obs_pop !== (5'b00001 << (i % N))) begin
                bad++; $display("FAIL rr_order cyc=%0d got=%b want=%b", i, obs_pop, 5'b00001 << (i % N));
            end
            if (out_valid !== m_ev || (m_ev && out_data !== m_ed)) begin
                bad++; $display("FAIL rr_out cyc=%0d got=%b/%h want=%b/%h", i, out_valid, out_data, m_ev, m_ed);
            end
            if (grant !== '0) begin bad++; $display("FAIL rr_grant cyc=%0d got=%b want=0", i, grant); end
        end
    endtask

    task automatic test_credit_stall();
        logic [N*DW-1:0] bus;
        bit              yum, want;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            bus = '0;
            bus[1*DW +: DW] = mk(i == 0 ? 6 : 1);
            yum  = (i == 8) || (i == 11) || (i == 13);
            want = (i < 4) || (i == 9) || (i == 12) || (i == 14);
            tick(5'b00010, bus, yum);
            total += 3;
            if (obs_pop !== (want ? 5'b00010 : 5'b00000) || obs_pop !== exp_pop) begin
                bad++; $display("FAIL credit_pop cyc=%0d got=%b want=%b", i, obs_pop, want ? 5'b00010 : 5'b00000);
            end
            if (out_valid !== m_ev || (m_ev && out_data !== m_ed)) begin
                bad++; $display("FAIL credit_out cyc=%0d got=%b/%h want=%b/%h", i, out_valid, out_data, m_ev, m_ed);
            end
            if (grant !== model_grant()) begin
                bad++; $display("FAIL credit_grant cyc=%0d got=%b want=%b", i, grant, model_grant());
            end
        end
    endtask

    task automatic test_stall_body();
        logic [N*DW-1:0] bus;
        logic [N-1:0]    v, want;
        for (int p = 0; p < 2; p++) begin
            do_reset();
            for (int i = 0; i < 7; i++) begin
                for (int j = 0; j < N; j++) bus[j*DW +: DW] = mk(0);
                bus[0 +: DW] = mk(i == 0 ? 2 : 5);
                case (i)
                    0:       begin v = 5'b00001; want = 5'b00001; end
                    1, 2, 3: begin v = 5'b11000; want = 5'b00000; end
                    4, 5:    begin v = 5'b11001; want = 5'b00001; end
                    default: begin v = p ? 5'b11010 : 5'b11000; want = p ? 5'b00010 : 5'b01000; end
                endcase
                tick(v, bus, out_valid);
                total += 3;
                if (obs_pop !== want || obs_pop !== exp_pop) begin
                    bad++; $display("FAIL stall_pop pass=%0d cyc=%0d got=%b want=%b", p, i, obs_pop, want);
                end
                if (grant !== model_grant()) begin
                    bad++; $display("FAIL stall_grant pass=%0d cyc=%0d got=%b want=%b", p, i, grant, model_grant());
                end
                if (out_valid !== m_ev || (m_ev && out_data !== m_ed)) begin
                    bad++; $display("FAIL stall_out pass=%0d cyc=%0d got=%b/%h want=%b/%h", p, i, out_valid, out_data, m_ev, m_ed);
                end
            end
        end
    endtask

    task automatic test_credit_err();
        logic [N*DW-1:0] bus;
        int              pops = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < N; j++) bus[j*DW +: DW] = mk(0);
            tick((i < 4) ? 5'b00000 : 5'b11111, bus, i == 0);
            if (obs_pop != '0) pops++;
            total += 2;
            if (credit_err !== 1'b1) begin bad++; $display("FAIL err_sticky cyc=%0d got=%b want=1", i, credit_err); end
            if (obs_pop !== exp_pop) begin bad++; $display("FAIL err_pop cyc=%0d got=%b want=%b", i, obs_pop, exp_pop); end
        end
        total++;
        if (pops !== CR) begin bad++; $display("FAIL err_credit_pops got=%0d want=%0d", pops, CR); end
    endtask

    task automatic test_reset_mid_body();
        logic [N*DW-1:0] bus;
        int              pops = 0;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            bus = '0;
            bus[3*DW +: DW] = mk(i == 0 ? 3 : 0);
            tick(5'b01000, bus, out_valid);
        end
        total++;
        if (grant !== 5'b01000) begin bad++; $display("FAIL midrst_pre_grant got=%b want=01000", grant); end
        #2;
        rst_n = 1'b0;
        #1;
        total += 3;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
        if (grant !== '0) begin bad++; $display("FAIL midrst_grant got=%b want=0", grant); end
        if (credit_err !== 1'b0) begin bad++; $display("FAIL midrst_err got=%b want=0", credit_err); end
        in_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            bus = '0;
            bus[4*DW +: DW] = mk(i == 0 ? 1 : 0);
            tick(5'b10000, bus, 1'b0);
            if (obs_pop != '0) pops++;
            total += 2;
            if (grant !== ((i == 0) ? 5'b10000 : 5'b00000)) begin
                bad++; $display("FAIL midrst_new_grant cyc=%0d got=%b", i, grant);
            end
            if (out_valid !== m_ev || (m_ev && out_data !== m_ed)) begin
                bad++; $display("FAIL midrst_out cyc=%0d got=%b/%h want=%b/%h", i, out_valid, out_data, m_ev, m_ed);
            end
        end
        total++;
        if (pops !== CR) begin bad++; $display("FAIL midrst_credit_pops got=%0d want=%0d", pops, CR); end
    endtask

    task automatic test_random();
        logic [N*DW-1:0] bus;
        logic            y;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int j = 0; j < N; j++) bus[j*DW +: DW] = mk(int'($urandom_range(0, 3)));
            y = (m_credit < CR) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 49) == 0);
            tick(N'($urandom), bus, y);
            total += 4;
            if (obs_pop !== exp_pop) begin
                bad++; $display("FAIL rand_pop cyc=%0d got=%b want=%b", i, obs_pop, exp_pop);
            end
            if (out_valid !== m_ev || (m_ev && out_data !== m_ed)) begin
                bad++; $display("FAIL rand_out cyc=%0d got=%b/%h want=%b/%h", i, out_valid, out_data, m_ev, m_ed);
            end
            if (grant !== model_grant()) begin
                bad++; $display("FAIL rand_grant cyc=%0d got=%b want=%b", i, grant, model_grant());
            end
            if (credit_err !== m_err) begin
                bad++; $display("FAIL rand_err cyc=%0d got=%b want=%b", i, credit_err, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_credit_stall();
        test_stall_body();
        test_credit_err();
        test_reset_mid_body();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
